// File: rtl/if_stage_prefetch_pkg.sv
// Shared constants and elaboration helpers for the instruction-fetch stage.
package if_stage_prefetch_pkg;

    localparam logic [31:0] NOP_INSTR       = 32'b0;
    localparam int          DEFAULT_PC_STEP = 4;

    // Ceiling log2, usable in parameter and port-range expressions.
    function automatic int log2c(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/if_stage_prefetch_fifo.sv
// Prefetch queue: circular buffer with wrapping pointers; occupancy comes from an explicit count.
module if_stage_prefetch_fifo
    import if_stage_prefetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      head,
    output logic [log2c(DEPTH):0] count,
    output logic                  empty,
    output logic                  full
);

    localparam int AW    = log2c(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Flush wins over any push or pop arriving on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage: PC generator, 1-cycle synchronous ROM and a prefetch queue
// feeding IF/ID. Redirects squash both the queue and any read still in flight.
module if_stage_prefetch
    import if_stage_prefetch_pkg::*;
#(
    parameter int                                ADDR_W     = 32,
    parameter int                                DATA_W     = 32,
    parameter int                                IMEM_DEPTH = 64,
    parameter int                                PC_STEP    = DEFAULT_PC_STEP,
    parameter int                                QDEPTH     = 4,
    parameter logic [ADDR_W-1:0]                 RESET_PC   = '0,
    parameter logic [ADDR_W-1:0]                 END_PC     = ADDR_W'((IMEM_DEPTH - 1) * PC_STEP),
    // ROM image; the all-zero default is an all-NOP program.
    parameter logic [IMEM_DEPTH-1:0][DATA_W-1:0] ROM_INIT   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              Branch_taken,
    input  logic [ADDR_W-1:0] BranchAddr,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] Instruction,
    output logic              valid
);

    localparam int                STEP_SH = log2c(PC_STEP);
    localparam int                IDX_W   = (IMEM_DEPTH > 1) ? log2c(IMEM_DEPTH) : 1;
    localparam int                CNT_W   = log2c(QDEPTH) + 1;
    localparam int                CR_W    = CNT_W + 1;
    localparam int                ENTRY_W = ADDR_W + DATA_W;
    localparam logic [DATA_W-1:0] NOP     = DATA_W'(NOP_INSTR);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  next_pc;
    logic [ADDR_W-1:0]  rd_pc;
    logic [DATA_W-1:0]  rd_data;
    logic               inflight;
    logic [ADDR_W-1:0]  word_addr;
    logic [IDX_W-1:0]   rom_idx;
    logic               in_range;
    logic [DATA_W-1:0]  rom_word;
    logic               pop;
    logic               issue;
    logic [CR_W-1:0]    credit;
    logic [ENTRY_W-1:0] head;
    logic [ADDR_W-1:0]  head_pc;
    logic [DATA_W-1:0]  head_instr;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic               fifo_full;

    // Low PC bits below the instruction step never select a ROM word.
    assign word_addr = fetch_pc >> STEP_SH;
    assign in_range  = word_addr < ADDR_W'(IMEM_DEPTH);
    assign rom_idx   = word_addr[IDX_W-1:0];
    assign rom_word  = in_range ? ROM_INIT[rom_idx] : NOP;
    assign next_pc   = (fetch_pc == END_PC) ? RESET_PC : fetch_pc + ADDR_W'(PC_STEP);

    // Issue only if the slot is still free once the returning read and this cycle's pop settle.
    assign pop    = valid && !freeze;
    assign credit = {1'b0, fifo_count} + CR_W'(inflight) - CR_W'(pop);
    assign issue  = !Branch_taken && (credit < CR_W'(QDEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            rd_pc    <= '0;
            rd_data  <= NOP;
        end else if (Branch_taken) begin
            fetch_pc <= BranchAddr;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                rd_pc    <= fetch_pc;
                rd_data  <= rom_word;
                fetch_pc <= next_pc;
            end
        end
    end

    if_stage_prefetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .flush (Branch_taken),
        .din   ({rd_pc, rd_data}),
        .head  (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign head_pc     = head[DATA_W +: ADDR_W];
    assign head_instr  = head[DATA_W-1:0];
    assign valid       = !fifo_empty;
    assign PC          = valid ? head_pc + ADDR_W'(PC_STEP) : '0;
    assign Instruction = valid ? head_instr : NOP;

    // A returning read must always find room; the credit check above is what guarantees it.
    assert property (@(posedge clk) disable iff (!rst) !(inflight && !pop && fifo_full));

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Bench for if_stage_prefetch: a 64-word DUT and an 8-word wrap DUT share one stimulus stream
// and are compared against a queue-level model of the fetch stage.
module tb_if_stage_prefetch;

    localparam int QDEPTH = 4;

    typedef logic [63:0][31:0] image_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    function automatic logic [31:0] img_word(input int i);
        logic [31:0] v;
        v = i;
        return {8'hC3, v[7:0], 8'(i * 3 + 7), ~v[7:0]};
    endfunction

    function automatic image_t build_image();
        image_t r;
        for (int i = 0; i < 64; i++) begin
            r[i] = img_word(i);
        end
        return r;
    endfunction

    localparam image_t          IMG  = build_image();
    localparam logic [7:0][31:0] IMG8 = IMG[7:0];

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        valid;
    logic [31:0] w_pc;
    logic [31:0] w_instruction;
    logic        w_valid;

    int vectors;
    int miscompares;

    if_stage_prefetch #(
        .ROM_INIT (IMG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .Branch_taken (branch_taken),
        .BranchAddr   (branch_addr),
        .PC           (pc),
        .Instruction  (instruction),
        .valid        (valid)
    );

    if_stage_prefetch #(
        .IMEM_DEPTH (8),
        .END_PC     (32'h1C),
        .ROM_INIT   (IMG8)
    ) dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .Branch_taken (branch_taken),
        .BranchAddr   (branch_addr),
        .PC           (w_pc),
        .Instruction  (w_instruction),
        .valid        (w_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: per instance, a list of queued entries, one pending read and the next fetch PC.
    entry_t      mlist  [2][8];
    int          mcnt   [2];
    logic [31:0] mfetch [2];
    bit          mpend  [2];
    entry_t      mpent  [2];

    function automatic int depth_of(input int inst);
        return (inst == 0) ? 64 : 8;
    endfunction

    function automatic logic [31:0] end_of(input int inst);
        return (inst == 0) ? 32'hFC : 32'h1C;
    endfunction

    function automatic logic [31:0] rom_word(input int inst, input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr >> 2;
        if (idx >= 32'(depth_of(inst))) return 32'h0;
        return img_word(int'(idx));
    endfunction

    function automatic bit exp_valid(input int inst);
        return mcnt[inst] > 0;
    endfunction

    function automatic logic [31:0] exp_pc(input int inst);
        return mlist[inst][0].pc + 32'd4;
    endfunction

    function automatic logic [31:0] exp_instr(input int inst);
        return mlist[inst][0].instr;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mcnt[i]   = 0;
            mpend[i]  = 1'b0;
            mfetch[i] = 32'h0;
        end
    endtask

    task automatic model_step(input int inst);
        bit do_pop;
        bit do_issue;
        if (!rst) begin
            mcnt[inst] = 0; mpend[inst] = 1'b0; mfetch[inst] = 32'h0;
            return;
        end
        if (branch_taken) begin
            mcnt[inst] = 0; mpend[inst] = 1'b0; mfetch[inst] = branch_addr;
            return;
        end
        do_pop   = (mcnt[inst] > 0) && !freeze;
        do_issue = (mcnt[inst] + int'(mpend[inst]) - int'(do_pop)) < QDEPTH;
        if (do_pop) begin
            for (int k = 0; k < 7; k++) mlist[inst][k] = mlist[inst][k+1];
            mcnt[inst]--;
        end
        if (mpend[inst]) begin
            mlist[inst][mcnt[inst]] = mpent[inst];
            mcnt[inst]++;
        end
        mpend[inst] = do_issue;
        if (do_issue) begin
            mpent[inst]  = '{pc: mfetch[inst], instr: rom_word(inst, mfetch[inst])};
            mfetch[inst] = (mfetch[inst] == end_of(inst)) ? 32'h0 : mfetch[inst] + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (valid !== 1'b0 || pc !== 32'h0 || instruction !== 32'h0 || w_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_hold cyc %0d: valid=%b pc=%h instr=%h w_valid=%b, want 0/0/0/0",
                         c, valid, pc, instruction, w_valid);
            end
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_first_edge: valid=%b, want 0", valid);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if (valid !== 1'b1 || pc !== 32'(4 * (k + 1)) || instruction !== img_word(k)) begin
                miscompares++;
                $display("[TB] FAIL reset_stream %0d: valid=%b pc=%h instr=%h, want 1/%h/%h",
                         k, valid, pc, instruction, 32'(4 * (k + 1)), img_word(k));
            end
        end
    endtask

    task automatic test_freeze();
        logic [31:0] held_pc;
        logic [31:0] held_instr;
        logic [31:0] want;
        held_pc    = exp_pc(0);
        held_instr = exp_instr(0);
        freeze = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (valid !== 1'b1 || pc !== held_pc || instruction !== held_instr) begin
                miscompares++;
                $display("[TB] FAIL freeze_hold cyc %0d: valid=%b pc=%h instr=%h, want 1/%h/%h",
                         c, valid, pc, instruction, held_pc, held_instr);
            end
        end
        freeze = 1'b0;
        want = held_pc;
        for (int c = 0; c < 8; c++) begin
            tick();
            want = want + 32'd4;
            vectors++;
            if (valid !== 1'b1 || pc !== want || instruction !== rom_word(0, want - 32'd4)) begin
                miscompares++;
                $display("[TB] FAIL freeze_release cyc %0d: valid=%b pc=%h instr=%h, want 1/%h/%h",
                         c, valid, pc, instruction, want, rom_word(0, want - 32'd4));
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] want;
        branch_taken = 1'b1; branch_addr = 32'h20;
        tick();
        branch_taken = 1'b0;
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL branch_e: valid=%b, want 0", valid);
        end
        tick();
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL branch_e1: valid=%b, want 0", valid);
        end
        want = 32'h24;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (valid !== 1'b1 || pc !== want || instruction !== img_word(8 + c)) begin
                miscompares++;
                $display("[TB] FAIL branch_stream %0d: valid=%b pc=%h instr=%h, want 1/%h/%h",
                         c, valid, pc, instruction, want, img_word(8 + c));
            end
            want = want + 32'd4;
        end
    endtask

    task automatic test_branch_freeze();
        freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h10;
        tick();
        branch_taken = 1'b0;
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL brfrz_e: valid=%b, want 0", valid);
        end
        tick();
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL brfrz_e1: valid=%b, want 0", valid);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (valid !== 1'b1 || pc !== 32'h14 || instruction !== img_word(4)) begin
                miscompares++;
                $display("[TB] FAIL brfrz_hold cyc %0d: valid=%b pc=%h instr=%h, want 1/00000014/%h",
                         c, valid, pc, instruction, img_word(4));
            end
        end
        freeze = 1'b0;
        tick();
        vectors++;
        if (valid !== 1'b1 || pc !== 32'h18 || instruction !== img_word(5)) begin
            miscompares++;
            $display("[TB] FAIL brfrz_release: valid=%b pc=%h instr=%h, want 1/00000018/%h",
                     valid, pc, instruction, img_word(5));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want;
        freeze = 1'b0; branch_taken = 1'b1; branch_addr = 32'h14;
        tick();
        branch_taken = 1'b0;
        tick();
        want = 32'h18;
        for (int c = 0; c < 20; c++) begin
            tick();
            vectors++;
            if (w_valid !== 1'b1 || w_pc !== want || w_instruction !== img_word(int'((want - 32'd4) >> 2))) begin
                miscompares++;
                $display("[TB] FAIL wrap cyc %0d: valid=%b pc=%h instr=%h, want 1/%h/%h",
                         c, w_valid, w_pc, w_instruction, want, img_word(int'((want - 32'd4) >> 2)));
            end
            want = (want == 32'h20) ? 32'h04 : want + 32'd4;
        end
    endtask

    task automatic test_async_reset();
        freeze = 1'b0; branch_taken = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        #3;
        rst = 1'b0;
        #1;
        vectors++;
        if (valid !== 1'b0 || w_valid !== 1'b0 || pc !== 32'h0 || instruction !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_now: valid=%b w_valid=%b pc=%h instr=%h, want 0/0/0/0",
                     valid, w_valid, pc, instruction);
        end
        model_reset();
        tick();
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_restart_first_edge: valid=%b, want 0", valid);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (valid !== 1'b1 || pc !== 32'(4 * (k + 1)) || instruction !== img_word(k)) begin
                miscompares++;
                $display("[TB] FAIL async_restart_stream %0d: valid=%b pc=%h instr=%h, want 1/%h/%h",
                         k, valid, pc, instruction, 32'(4 * (k + 1)), img_word(k));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            freeze       = ($urandom_range(0, 99) < 30);
            branch_taken = ($urandom_range(0, 99) < 7);
            case ($urandom_range(0, 2))
                0:       branch_addr = 32'($urandom_range(0, 63)) << 2;
                1:       branch_addr = 32'($urandom_range(0, 255));
                default: branch_addr = 32'h100 + (32'($urandom_range(0, 63)) << 2);
            endcase
            tick();
            vectors++;
            if (valid !== exp_valid(0)) begin
                miscompares++;
                $display("[TB] FAIL random_valid cyc %0d: got %b want %b", c, valid, exp_valid(0));
            end
            if (exp_valid(0)) begin
                vectors++;
                if (pc !== exp_pc(0) || instruction !== exp_instr(0)) begin
                    miscompares++;
                    $display("[TB] FAIL random_head cyc %0d: pc=%h instr=%h want %h/%h",
                             c, pc, instruction, exp_pc(0), exp_instr(0));
                end
            end
            vectors++;
            if (w_valid !== exp_valid(1)) begin
                miscompares++;
                $display("[TB] FAIL random_wrap_valid cyc %0d: got %b want %b", c, w_valid, exp_valid(1));
            end
            if (exp_valid(1)) begin
                vectors++;
                if (w_pc !== exp_pc(1) || w_instruction !== exp_instr(1)) begin
                    miscompares++;
                    $display("[TB] FAIL random_wrap_head cyc %0d: pc=%h instr=%h want %h/%h",
                             c, w_pc, w_instruction, exp_pc(1), exp_instr(1));
                end
            end
        end
        freeze = 1'b0;
        branch_taken = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        test_reset();
        test_freeze();
        test_branch();
        test_branch_freeze();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
